// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// ----------------------------------------------------------------------------
// Packet-granular round-robin arbiter that shares the single 10G MAC TX
// AXI-Stream port between two sources in the clk156 domain:
//   port 0 : encapsulation / reply path
//   port 1 : local control / probe generator
// Once a port is granted, its beats are passed straight through, with no
// added latency, until its tlast is accepted. Packets from the two ports are
// never interleaved. Arbitration costs one IDLE cycle between packets. When
// both ports request at once, the port that was not served last wins, so two
// saturated ports alternate 0,1,0,1...
//
// Optional build macro: ETH_TX_ARB_WATCHDOG_EN
//   When this macro is defined, a granted port that holds tvalid low for
//   TIMEOUT consecutive cycles mid-packet causes the arbiter to do three
//   things. It emits one errored abort beat (tlast=1, tuser=1, tkeep=1,
//   tdata=0). It then silently drains the rest of that packet from the
//   source. Finally it counts the event in timeout_cnt. Without the macro,
//   a granted port is waited on indefinitely and timeout_cnt is tied to 0.
//
// Ports
//   clk156          : 156.25 MHz MAC core clock, the only clock
//   eth_rst         : synchronous, active-high reset
//   s0_axis_*       : source 0 AXI-Stream slave (tvalid/tready/tdata/tkeep/tlast/tuser)
//   s1_axis_*       : source 1 AXI-Stream slave
//   m_axis_*        : AXI-Stream master towards the MAC s_axis_tx interface
//   grant           : one-hot active grant (bit0 = port 0, bit1 = port 1, 00 = idle)
//   pkt_cnt0/1      : packets forwarded per port, wrapping 16-bit counters
//   timeout_cnt     : watchdog aborts, saturating at 8'hFF
// ----------------------------------------------------------------------------
module eth_tx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk156,
    input  logic                  eth_rst,

    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tlast,
    input  logic                  s0_axis_tuser,

    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tlast,
    input  logic                  s1_axis_tuser,

    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,

    output logic [1:0]            grant,
    output logic [15:0]           pkt_cnt0,
    output logic [15:0]           pkt_cnt1,
    output logic [7:0]            timeout_cnt
);

    // The stall counter needs at least one bit.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("eth_tx_arbiter: TIMEOUT must be at least 2");
    end

`ifdef ETH_TX_ARB_WATCHDOG_EN
    typedef enum logic [2:0] {IDLE, BUSY0, BUSY1, ABORT, DRAIN} state_t;

    // The counter only ever needs to hold values up to TIMEOUT-1.
    localparam int STALL_W = $clog2(TIMEOUT);

    logic [STALL_W-1:0] stall_cnt;
    logic [7:0]         timeout_q;

    assign timeout_cnt = timeout_q;
`else
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    assign timeout_cnt = 8'd0;
`endif

    state_t state;
    logic   cur_port;   // Port that owns the packet in flight (0 or 1).
    logic   last_port;  // Port served last; the other port wins a tie.

    // Signals of the port that owns the current packet.
    logic                  sel_tvalid;
    logic [DATA_WIDTH-1:0] sel_tdata;
    logic [KEEP_WIDTH-1:0] sel_tkeep;
    logic                  sel_tlast;
    logic                  sel_tuser;

    assign sel_tvalid = cur_port ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_tdata  = cur_port ? s1_axis_tdata  : s0_axis_tdata;
    assign sel_tkeep  = cur_port ? s1_axis_tkeep  : s0_axis_tkeep;
    assign sel_tlast  = cur_port ? s1_axis_tlast  : s0_axis_tlast;
    assign sel_tuser  = cur_port ? s1_axis_tuser  : s0_axis_tuser;

    // Last beat of the granted packet is accepted by the MAC this cycle.
    logic pkt_done;
    assign pkt_done = sel_tvalid & sel_tlast & m_axis_tready;

    // The data path is a combinational pass-through so that a granted
    // packet sees no added latency and no extra pipeline stage.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves a signal unassigned and no latch is inferred.
        m_axis_tvalid  = 1'b0;
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state)
            BUSY0, BUSY1: begin
                m_axis_tvalid  = sel_tvalid;
                m_axis_tdata   = sel_tdata;
                m_axis_tkeep   = sel_tkeep;
                m_axis_tlast   = sel_tlast;
                m_axis_tuser   = sel_tuser;
                s0_axis_tready = m_axis_tready & ~cur_port;
                s1_axis_tready = m_axis_tready &  cur_port;
            end
`ifdef ETH_TX_ARB_WATCHDOG_EN
            // A single errored beat closes the frame the MAC has already started.
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                m_axis_tkeep  = KEEP_WIDTH'(1);
            end
            // Swallow the rest of the stalled packet so the source can finish cleanly.
            DRAIN: begin
                s0_axis_tready = ~cur_port;
                s1_axis_tready =  cur_port;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk156) begin
        // NOTE: all state updates use non-blocking assignments, so every
        // register samples values from before the clock edge and the result
        // does not depend on statement order.
        if (eth_rst) begin
            state     <= IDLE;
            cur_port  <= 1'b0;
            last_port <= 1'b1;
            grant     <= 2'b00;
            pkt_cnt0  <= 16'd0;
            pkt_cnt1  <= 16'd0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            stall_cnt <= '0;
            timeout_q <= 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // Port 0 wins when it is the only requester, or on a tie
                    // when port 1 was served last.
                    if (s0_axis_tvalid && (!s1_axis_tvalid || last_port)) begin
                        state    <= BUSY0;
                        cur_port <= 1'b0;
                        grant    <= 2'b01;
                    end else if (s1_axis_tvalid) begin
                        state    <= BUSY1;
                        cur_port <= 1'b1;
                        grant    <= 2'b10;
                    end
`ifdef ETH_TX_ARB_WATCHDOG_EN
                    stall_cnt <= '0;
`endif
                end

                BUSY0, BUSY1: begin
                    if (pkt_done) begin
                        if (cur_port) pkt_cnt1 <= pkt_cnt1 + 16'd1;
                        else          pkt_cnt0 <= pkt_cnt0 + 16'd1;
                        last_port <= cur_port;
                        grant     <= 2'b00;
                        state     <= IDLE;
                    end
`ifdef ETH_TX_ARB_WATCHDOG_EN
                    // Only source silence counts as a stall. Back-pressure
                    // from the MAC does not.
                    else if (sel_tvalid) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                        stall_cnt <= '0;
                        state     <= ABORT;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`endif
                end

`ifdef ETH_TX_ARB_WATCHDOG_EN
                ABORT: begin
                    if (m_axis_tready) begin
                        if (timeout_q != 8'hFF) timeout_q <= timeout_q + 8'd1;
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (sel_tvalid && sel_tlast) begin
                        last_port <= cur_port;
                        grant     <= 2'b00;
                        state     <= IDLE;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule
